branch_resolve_ctrl: RTL and testbench

- Sits in the EX stage, directly downstream of the branch-condition evaluator; consumes its branch_taken result.
- Compares the actual outcome with the prediction carried down the pipe from IF.
- On a mispredict, issues a PC redirect to fetch over a valid/ready handshake and flushes the IF/ID and ID/EX registers.
- Owns a bimodal branch history table (BHT) of 2-bit saturating counters, read by IF and trained from EX.

---
 rtl/branch_resolve_ctrl_if.sv | 59 +++++
 rtl/branch_resolve_ctrl.sv | 172 +++++++++++++++++
 tb/tb_branch_resolve_ctrl.sv | 232 +++++++++++++++++++++++
 3 files changed

// File: rtl/branch_resolve_ctrl_if.sv
// Signal bundle between the EX-stage branch resolver, the fetch unit and the pipeline
// registers: EX resolution inputs, BHT lookup, the redirect handshake and the flush/stall controls.
interface branch_resolve_ctrl_if #(
    parameter int unsigned XLEN = 32'd64
);
    logic            ex_valid;
    logic            ex_is_branch;
    logic            ex_is_jump;
    logic            ex_branch_taken;
    logic            ex_pred_taken;
    logic [XLEN-1:0] ex_pc;
    logic [XLEN-1:0] ex_target;
    logic [XLEN-1:0] if_pc;
    logic            if_pred_taken;
    logic            redir_valid;
    logic            redir_ready;
    logic [XLEN-1:0] redir_pc;
    logic            flush_if_id;
    logic            flush_id_ex;
    logic            stall_ex;

    // Resolver side: originates the redirect request and the pipeline controls.
    modport master (
        input  ex_valid,
        input  ex_is_branch,
        input  ex_is_jump,
        input  ex_branch_taken,
        input  ex_pred_taken,
        input  ex_pc,
        input  ex_target,
        input  if_pc,
        input  redir_ready,
        output if_pred_taken,
        output redir_valid,
        output redir_pc,
        output flush_if_id,
        output flush_id_ex,
        output stall_ex
    );

    // Pipeline / fetch side: supplies EX results and accepts the redirect.
    modport slave (
        output ex_valid,
        output ex_is_branch,
        output ex_is_jump,
        output ex_branch_taken,
        output ex_pred_taken,
        output ex_pc,
        output ex_target,
        output if_pc,
        output redir_ready,
        input  if_pred_taken,
        input  redir_valid,
        input  redir_pc,
        input  flush_if_id,
        input  flush_id_ex,
        input  stall_ex
    );
endinterface

// File: rtl/branch_resolve_ctrl.sv
// EX-stage branch resolution: mispredict detection, fetch redirect handshake, pipeline flush
// and a bimodal 2-bit BHT. Optional perf counters are built when BRANCH_STATS_EN is defined.
module branch_resolve_ctrl #(
    parameter int unsigned BHT_IDX_W = 32'd6,
    parameter int unsigned XLEN      = 32'd64
) (
    input  logic                   clk,
    input  logic                   rst,
    branch_resolve_ctrl_if.master  bus
`ifdef BRANCH_STATS_EN
    ,
    output logic [31:0]            perf_branch_cnt,
    output logic [31:0]            perf_mispred_cnt
`endif
);

    localparam int unsigned BHT_DEPTH = 32'd1 << BHT_IDX_W;
    localparam logic [XLEN-1:0] PC_STEP = {{(XLEN-3){1'b0}}, 3'b100};

    typedef enum logic [0:0] {
        ST_IDLE     = 1'b0,
        ST_REDIRECT = 1'b1
    } state_e;

    state_e                state_r;
    state_e                state_nxt_s;
    logic                  redir_valid_r;
    logic                  redir_valid_nxt_s;
    logic [XLEN-1:0]       redir_pc_r;
    logic [XLEN-1:0]       redir_pc_nxt_s;
    logic                  flush_r;
    logic                  flush_nxt_s;

    logic                  actual_s;
    logic                  resolve_s;
    logic                  mispredict_s;
    logic [XLEN-1:0]       correct_pc_s;

    logic [1:0]            bht_r [BHT_DEPTH];
    logic [BHT_IDX_W-1:0]  lookup_idx_s;
    logic [BHT_IDX_W-1:0]  train_idx_s;
    logic                  train_en_s;
    logic [1:0]            train_val_s;
    logic                  unused_s;

    // Two-bit saturating counter step toward the observed direction.
    function automatic logic [1:0] sat_update(input logic [1:0] cnt, input logic taken);
        logic [1:0] res;
        if (taken) begin
            res = (cnt == 2'b11) ? 2'b11 : cnt + 2'b01;
        end else begin
            res = (cnt == 2'b00) ? 2'b00 : cnt - 2'b01;
        end
        return res;
    endfunction

    assign actual_s     = bus.ex_is_jump | (bus.ex_is_branch & bus.ex_branch_taken);
    assign resolve_s    = bus.ex_valid & (bus.ex_is_branch | bus.ex_is_jump);
    assign mispredict_s = resolve_s & (actual_s != bus.ex_pred_taken);
    assign correct_pc_s = actual_s ? bus.ex_target : (bus.ex_pc + PC_STEP);

    assign lookup_idx_s = bus.if_pc[BHT_IDX_W+1:2];
    assign train_idx_s  = bus.ex_pc[BHT_IDX_W+1:2];
    assign unused_s     = ^{bus.if_pc[XLEN-1:BHT_IDX_W+2], bus.if_pc[1:0]};

    // Prediction read is straight from the table; an update on this edge shows up next cycle.
    assign bus.if_pred_taken = bht_r[lookup_idx_s][1];

    // Training request: only conditional branches, and only while not holding a redirect.
    always_comb begin
        train_en_s  = 1'b0;
        train_val_s = bht_r[train_idx_s];
        if ((state_r == ST_IDLE) && bus.ex_valid && bus.ex_is_branch) begin
            train_en_s  = 1'b1;
            train_val_s = sat_update(bht_r[train_idx_s], bus.ex_branch_taken);
        end else begin
            train_en_s  = 1'b0;
        end
    end

    // BHT storage; every entry starts weakly not-taken.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            bht_r <= '{default: 2'b01};
        end else if (train_en_s) begin
            bht_r[train_idx_s] <= train_val_s;
        end
    end

    // FSM and registered redirect/flush outputs.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state_r       <= ST_IDLE;
            redir_valid_r <= 1'b0;
            redir_pc_r    <= {XLEN{1'b0}};
            flush_r       <= 1'b0;
        end else begin
            state_r       <= state_nxt_s;
            redir_valid_r <= redir_valid_nxt_s;
            redir_pc_r    <= redir_pc_nxt_s;
            flush_r       <= flush_nxt_s;
        end
    end

    // Next-state logic; redir_pc is frozen for the whole REDIRECT episode.
    always_comb begin
        state_nxt_s       = state_r;
        redir_valid_nxt_s = redir_valid_r;
        redir_pc_nxt_s    = redir_pc_r;
        flush_nxt_s       = flush_r;
        case (state_r)
            ST_IDLE: begin
                if (mispredict_s) begin
                    state_nxt_s       = ST_REDIRECT;
                    redir_valid_nxt_s = 1'b1;
                    redir_pc_nxt_s    = correct_pc_s;
                    flush_nxt_s       = 1'b1;
                end else begin
                    state_nxt_s       = ST_IDLE;
                    redir_valid_nxt_s = 1'b0;
                    flush_nxt_s       = 1'b0;
                end
            end
            ST_REDIRECT: begin
                if (redir_valid_r && bus.redir_ready) begin
                    state_nxt_s       = ST_IDLE;
                    redir_valid_nxt_s = 1'b0;
                    flush_nxt_s       = 1'b0;
                end else begin
                    state_nxt_s       = ST_REDIRECT;
                    redir_valid_nxt_s = 1'b1;
                    flush_nxt_s       = 1'b1;
                end
            end
            default: begin
                state_nxt_s       = ST_IDLE;
                redir_valid_nxt_s = 1'b0;
                flush_nxt_s       = 1'b0;
            end
        endcase
    end

    assign bus.redir_valid = redir_valid_r;
    assign bus.redir_pc    = redir_pc_r;
    assign bus.flush_if_id = flush_r;
    assign bus.flush_id_ex = flush_r;
    assign bus.stall_ex    = (state_r == ST_REDIRECT);

`ifdef BRANCH_STATS_EN
    logic [31:0] perf_branch_r;
    logic [31:0] perf_mispred_r;

    // Saturating event counters; events seen while redirecting are not counted.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            perf_branch_r  <= 32'd0;
            perf_mispred_r <= 32'd0;
        end else begin
            if ((state_r == ST_IDLE) && resolve_s && (perf_branch_r != 32'hFFFF_FFFF)) begin
                perf_branch_r <= perf_branch_r + 32'd1;
            end
            if ((state_r == ST_IDLE) && mispredict_s && (perf_mispred_r != 32'hFFFF_FFFF)) begin
                perf_mispred_r <= perf_mispred_r + 32'd1;
            end
        end
    end

    assign perf_branch_cnt  = perf_branch_r;
    assign perf_mispred_cnt = perf_mispred_r;
`endif

endmodule

// File: tb/tb_branch_resolve_ctrl.sv
// Self-checking bench for branch_resolve_ctrl: directed scenarios plus random traffic,
// compared each cycle against a behavioural model of redirect state and BHT counters.
module tb_branch_resolve_ctrl;

    localparam int XLEN      = 64;
    localparam int BHT_IDX_W = 6;
    localparam int DEPTH     = 64;

    logic clk = 1'b0;
    logic rst;

    always #5 clk = ~clk;

    branch_resolve_ctrl_if #(.XLEN(XLEN)) bus ();

`ifdef BRANCH_STATS_EN
    logic [31:0] perf_branch_cnt;
    logic [31:0] perf_mispred_cnt;
`endif

    branch_resolve_ctrl #(.BHT_IDX_W(BHT_IDX_W), .XLEN(XLEN)) dut (
        .clk (clk),
        .rst (rst),
        .bus (bus)
`ifdef BRANCH_STATS_EN
        ,
        .perf_branch_cnt  (perf_branch_cnt),
        .perf_mispred_cnt (perf_mispred_cnt)
`endif
    );

    int n_checks = 0;
    int n_fail   = 0;

    // Reference model state
    int          m_bht [DEPTH];
    bit          m_pend;
    logic [63:0] m_rpc;
    longint      m_bcnt;
    longint      m_mcnt;

    task automatic check_val(input string tag, input logic [63:0] obs, input logic [63:0] exp);
        n_checks++;
        if (obs !== exp) begin
            n_fail++;
            $display("FAIL %s: observed %0h expected %0h at %0t", tag, obs, exp, $time);
        end
    endtask

    function automatic int idx_of(input logic [63:0] pc);
        return int'((pc >> 2) % 64'(DEPTH));
    endfunction

    task automatic model_reset();
        for (int i = 0; i < DEPTH; i++) m_bht[i] = 1;
        m_pend = 1'b0;
        m_rpc  = 64'h0;
        m_bcnt = 0;
        m_mcnt = 0;
    endtask

    task automatic check_outputs();
        check_val("redir_valid", {63'h0, bus.redir_valid}, {63'h0, m_pend});
        check_val("redir_pc", bus.redir_pc, m_rpc);
        check_val("flush_if_id", {63'h0, bus.flush_if_id}, {63'h0, m_pend});
        check_val("flush_id_ex", {63'h0, bus.flush_id_ex}, {63'h0, m_pend});
        check_val("stall_ex", {63'h0, bus.stall_ex}, {63'h0, m_pend});
        check_val("if_pred_taken", {63'h0, bus.if_pred_taken},
                  (m_bht[idx_of(bus.if_pc)] >= 2) ? 64'h1 : 64'h0);
`ifdef BRANCH_STATS_EN
        check_val("perf_branch_cnt", {32'h0, perf_branch_cnt}, 64'(m_bcnt));
        check_val("perf_mispred_cnt", {32'h0, perf_mispred_cnt}, 64'(m_mcnt));
`endif
    endtask

    // Advance the model by one clock edge using the inputs currently applied.
    task automatic model_step();
        bit act;
        int k;
        if (!m_pend) begin
            if (bus.ex_valid && (bus.ex_is_branch || bus.ex_is_jump)) begin
                act = bus.ex_is_jump || (bus.ex_is_branch && bus.ex_branch_taken);
                m_bcnt++;
                if (act != bus.ex_pred_taken) begin
                    m_mcnt++;
                    m_pend = 1'b1;
                    m_rpc  = act ? bus.ex_target : bus.ex_pc + 64'd4;
                end
            end
            if (bus.ex_valid && bus.ex_is_branch) begin
                k = idx_of(bus.ex_pc);
                if (bus.ex_branch_taken) m_bht[k] = (m_bht[k] == 3) ? 3 : m_bht[k] + 1;
                else                     m_bht[k] = (m_bht[k] == 0) ? 0 : m_bht[k] - 1;
            end
        end else if (bus.redir_ready) begin
            m_pend = 1'b0;
        end
    endtask

    task automatic cycle();
        #1;
        check_outputs();
        model_step();
        @(posedge clk);
        #1;
    endtask

    task automatic set_ex(input bit v, input bit br, input bit jp, input bit tk, input bit pr,
                          input logic [63:0] pc, input logic [63:0] tgt);
        bus.ex_valid        = v;
        bus.ex_is_branch    = br;
        bus.ex_is_jump      = jp;
        bus.ex_branch_taken = tk;
        bus.ex_pred_taken   = pr;
        bus.ex_pc           = pc;
        bus.ex_target       = tgt;
    endtask

    task automatic sweep_all_not_taken(input string tag);
        logic [63:0] p;
        for (int i = 0; i < DEPTH; i++) begin
            p = 64'(i) * 64'd4;
            bus.if_pc = p;
            #1;
            check_val(tag, {63'h0, bus.if_pred_taken}, 64'h0);
        end
    endtask

    initial begin
        logic [63:0] rpc;
        int          kind;
        bit          pr;

        rst = 1'b1;
        set_ex(1'b0, 1'b0, 1'b0, 1'b0, 1'b0, 64'h0, 64'h0);
        bus.redir_ready = 1'b0;
        bus.if_pc       = 64'h1000;
        model_reset();
        #12;
        check_outputs();
        sweep_all_not_taken("reset_pred");
        bus.if_pc = 64'h1000;
        @(posedge clk);
        #1;
        rst = 1'b0;

        // Taken mispredict, fetch ready immediately
        bus.redir_ready = 1'b1;
        bus.if_pc       = 64'h2000;
        set_ex(1'b1, 1'b1, 1'b0, 1'b1, 1'b0, 64'h2000, 64'h2040);
        cycle();
        set_ex(1'b0, 1'b0, 1'b0, 1'b0, 1'b0, 64'h0, 64'h0);
        check_val("taken_redir_pc", bus.redir_pc, 64'h2040);
        cycle();
        cycle();

        // Not-taken mispredict under backpressure; EX noise during the wait must be ignored
        bus.redir_ready = 1'b0;
        set_ex(1'b1, 1'b1, 1'b0, 1'b0, 1'b1, 64'h3000, 64'h3100);
        cycle();
        for (int i = 0; i < 3; i++) begin
            set_ex(1'b1, 1'b1, 1'b0, 1'b1, 1'b0, 64'h3000, 64'h5000 + 64'(i));
            bus.if_pc = 64'h3000;
            cycle();
        end
        bus.redir_ready = 1'b1;
        set_ex(1'b0, 1'b0, 1'b0, 1'b0, 1'b0, 64'h0, 64'h0);
        check_val("bp_redir_pc", bus.redir_pc, 64'h3004);
        cycle();
        cycle();

        // Saturation at index 0, each prediction taken from the current counter
        bus.if_pc = 64'h400;
        for (int i = 0; i < 5; i++) begin
            pr = (m_bht[0] >= 2);
            set_ex(1'b1, 1'b1, 1'b0, 1'b1, pr, 64'h400, 64'h800);
            cycle();
            set_ex(1'b0, 1'b0, 1'b0, 1'b0, 1'b0, 64'h0, 64'h0);
            cycle();
        end
        check_val("sat_pred", {63'h0, bus.if_pred_taken}, 64'h1);

        // Jump redirect, then wrap of pc+4
        set_ex(1'b1, 1'b0, 1'b1, 1'b0, 1'b0, 64'h600, 64'h80);
        cycle();
        set_ex(1'b0, 1'b0, 1'b0, 1'b0, 1'b0, 64'h0, 64'h0);
        check_val("jump_redir_pc", bus.redir_pc, 64'h80);
        cycle();
        set_ex(1'b1, 1'b1, 1'b0, 1'b0, 1'b1, 64'hFFFF_FFFF_FFFF_FFFC, 64'h1234);
        cycle();
        set_ex(1'b0, 1'b0, 1'b0, 1'b0, 1'b0, 64'h0, 64'h0);
        check_val("wrap_redir_pc", bus.redir_pc, 64'h0);
        cycle();
        cycle();

        // Random traffic
        for (int n = 0; n < 2000; n++) begin
            kind = $urandom_range(0, 3);
            rpc  = 64'h8000_0000 + 64'($urandom_range(0, 7)) * 64'd4
                 + (64'($urandom_range(0, 3)) << 8);
            pr   = ($urandom_range(0, 1) == 1) ? (m_bht[idx_of(rpc)] >= 2) : 1'($urandom_range(0, 1));
            set_ex(($urandom_range(0, 9) < 8), (kind == 1 || kind == 2), (kind == 3),
                   1'($urandom_range(0, 1)), pr, rpc, {32'($urandom), 32'($urandom)});
            bus.redir_ready = ($urandom_range(0, 1) == 1);
            bus.if_pc       = 64'h8000_0000 + 64'($urandom_range(0, 15)) * 64'd4;
            cycle();
        end

        // Reset while a redirect is waiting for acceptance
        bus.redir_ready = 1'b0;
        set_ex(1'b1, 1'b0, 1'b1, 1'b0, 1'b0, 64'h700, 64'h9000);
        cycle();
        set_ex(1'b0, 1'b0, 1'b0, 1'b0, 1'b0, 64'h0, 64'h0);
        cycle();
        check_val("pre_reset_valid", {63'h0, bus.redir_valid}, 64'h1);
        #2;
        rst = 1'b1;
        model_reset();
        #1;
        check_outputs();
        sweep_all_not_taken("midreset_pred");
        @(posedge clk);
        #1;
        rst = 1'b0;
        bus.if_pc = 64'h0;
        cycle();

        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end

endmodule
